// File: rtl/ov7670_frame_emulator.sv
// OV7670-style camera source: drives cam_pclk/cam_vsync/cam_href/cam_data (RGB565, MSB byte first).
// Latency: start/continuous seen in IDLE at edge k -> busy, cam_vsync high at edge k+1; frame_done pulses 590 clk later (defaults).
// Backpressure: none; the source free-runs once a frame begins, start while busy is ignored.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start, continuous   - single-frame request / free-running frames
//   pattern_sel, color_rgb565, plant_top, plant_bottom - pattern config, snapshotted at frame start
//   cam_pclk, cam_vsync, cam_href, cam_data           - emulated camera bus
//   busy, frame_done, frame_count                     - status
module ov7670_frame_emulator #(
    parameter int H_ACTIVE       = 16,
    parameter int V_ACTIVE       = 8,
    parameter int H_BLANK        = 4,
    parameter int VSYNC_W        = 3,
    parameter int V_BACK         = 2,
    parameter int V_FRONT        = 2,
    parameter bit VSYNC_ENVELOPE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        continuous,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] color_rgb565,
    input  logic [7:0]  plant_top,
    input  logic [7:0]  plant_bottom,
    output logic        cam_pclk,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  frame_count
);

    localparam int MAX_A = (VSYNC_W > V_BACK) ? VSYNC_W : V_BACK;
    localparam int MAX_B = (V_FRONT > H_BLANK) ? V_FRONT : H_BLANK;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_P = (MAX_C > 2*H_ACTIVE) ? MAX_C : 2*H_ACTIVE;
    localparam int CNT_W = $clog2(MAX_P + 1);

    localparam logic [CNT_W-1:0] VSYNC_LAST  = CNT_W'(VSYNC_W - 1);
    localparam logic [CNT_W-1:0] VBACK_LAST  = CNT_W'(V_BACK - 1);
    localparam logic [CNT_W-1:0] HBLANK_LAST = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] VFRONT_LAST = CNT_W'(V_FRONT - 1);
    localparam logic [9:0]       BYTE_LAST   = 10'(2*H_ACTIVE - 1);
    localparam logic [7:0]       ROW_LAST    = 8'(V_ACTIVE - 1);
    localparam logic [8:0]       PLANT_C0    = 9'(H_ACTIVE / 4);
    localparam logic [8:0]       PLANT_C1    = 9'(3*H_ACTIVE / 4);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_VSYNC, S_VBACK, S_LINE, S_HBLANK, S_VFRONT
    } state_t;

    state_t           state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic [7:0]       row, nxt_row;
    logic [9:0]       byte_idx, nxt_byte;
    logic             frame_end;

    logic [1:0]       cfg_pattern;
    logic [15:0]      cfg_color;
    logic [7:0]       cfg_top, cfg_bottom;

    logic [8:0]       col;
    logic [15:0]      pixel;
    logic             nxt_vsync, nxt_href;
    logic [7:0]       nxt_data;

    // Position of the next PCLK period; only consumed on period-start edges.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = '0;
        nxt_row   = row;
        nxt_byte  = '0;
        frame_end = 1'b0;
        case (state)
            S_VSYNC: begin
                if (cnt == VSYNC_LAST) nxt_state = S_VBACK;
                else                   nxt_cnt   = cnt + CNT_W'(1);
            end
            S_VBACK: begin
                if (cnt == VBACK_LAST) begin
                    nxt_state = S_LINE;
                    nxt_row   = '0;
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            S_LINE: begin
                if (byte_idx == BYTE_LAST) nxt_state = S_HBLANK;
                else                       nxt_byte  = byte_idx + 10'd1;
            end
            S_HBLANK: begin
                if (cnt == HBLANK_LAST) begin
                    if (row == ROW_LAST) begin
                        nxt_state = S_VFRONT;
                    end else begin
                        nxt_state = S_LINE;
                        nxt_row   = row + 8'd1;
                    end
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            S_VFRONT: begin
                if (cnt == VFRONT_LAST) frame_end = 1'b1;
                else                    nxt_cnt   = cnt + CNT_W'(1);
            end
            default: ;
        endcase
    end

    // Pixel for the next byte position, from the frame's snapshotted config.
    always_comb begin
        col   = nxt_byte[9:1];
        pixel = cfg_color;
        case (cfg_pattern)
            2'd0: pixel = cfg_color;
            2'd1: begin
                // An inverted top/bottom pair never satisfies both bounds, so no plant.
                if (nxt_row >= cfg_top && nxt_row <= cfg_bottom &&
                    col >= PLANT_C0 && col < PLANT_C1)
                    pixel = 16'h07E0;
            end
            2'd2: pixel = {5'b0, nxt_row[5:0], 5'b0};
            default: pixel = {col[2] ? 5'h1F : 5'h00,
                              col[1] ? 6'h3F : 6'h00,
                              col[0] ? 5'h1F : 5'h00};
        endcase
        nxt_href  = (nxt_state == S_LINE);
        nxt_vsync = (nxt_state == S_VSYNC) ||
                    (VSYNC_ENVELOPE && (nxt_state == S_VBACK ||
                                        nxt_state == S_LINE  ||
                                        nxt_state == S_HBLANK));
        nxt_data  = nxt_href ? (nxt_byte[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            row         <= '0;
            byte_idx    <= '0;
            cfg_pattern <= '0;
            cfg_color   <= '0;
            cfg_top     <= '0;
            cfg_bottom  <= '0;
            cam_pclk    <= 1'b0;
            cam_vsync   <= 1'b0;
            cam_href    <= 1'b0;
            cam_data    <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start || continuous) begin
                        cfg_pattern <= pattern_sel;
                        cfg_color   <= color_rgb565;
                        cfg_top     <= plant_top;
                        cfg_bottom  <= plant_bottom;
                        state       <= S_START;
                    end
                end
                S_START: begin
                    state     <= S_VSYNC;
                    cnt       <= '0;
                    row       <= '0;
                    byte_idx  <= '0;
                    busy      <= 1'b1;
                    cam_vsync <= 1'b1;
                    cam_pclk  <= 1'b0;
                    cam_href  <= 1'b0;
                    cam_data  <= '0;
                end
                default: begin
                    if (!cam_pclk) begin
                        // Second half of a PCLK period: bus held stable across the rising edge.
                        cam_pclk <= 1'b1;
                    end else if (frame_end) begin
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 8'd1;
                        cnt         <= '0;
                        row         <= '0;
                        byte_idx    <= '0;
                        cam_pclk    <= 1'b0;
                        cam_href    <= 1'b0;
                        cam_data    <= '0;
                        if (continuous) begin
                            // Back-to-back frame: VSYNC starts on this same edge.
                            cfg_pattern <= pattern_sel;
                            cfg_color   <= color_rgb565;
                            cfg_top     <= plant_top;
                            cfg_bottom  <= plant_bottom;
                            state       <= S_VSYNC;
                            cam_vsync   <= 1'b1;
                        end else begin
                            state     <= S_IDLE;
                            cam_vsync <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end else begin
                        state     <= nxt_state;
                        cnt       <= nxt_cnt;
                        row       <= nxt_row;
                        byte_idx  <= nxt_byte;
                        cam_pclk  <= 1'b0;
                        cam_vsync <= nxt_vsync;
                        cam_href  <= nxt_href;
                        cam_data  <= nxt_data;
                    end
                end
            endcase
        end
    end

endmodule
